reaction_match_mode: RTL and testbench
======================================

REACTION_MATCH_MODE -- requirements
Module: reaction_match_mode

Interface
REQ-001 Parameter N_SW, default 8, number of switch/target LED channels (legal range 2..16).
REQ-002 Parameter CNT_W, default 24, width of the reaction time counter and highscore.
REQ-003 Parameter ARM_CYCLES, default 1500, number of cin cycles between start and target display (≥1).
REQ-004 Parameter TIMEOUT, default 5000000, cycle limit for a round (1 < TIMEOUT < 2^CNT_W - 1).
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 cin  input  1  clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 selection  input  1  mode enable; low forces the block idle.
REQ-009 key  input  1  start button, active-high, synchronous to cin.
REQ-010 sw  input  N_SW  player switch pattern.
REQ-011 light  output  N_SW  target pattern shown to player; zero when not in SHOW.
REQ-012 armed  output  1  high in ARM state.
REQ-013 signal  output  1  one-cycle pulse on a successful match.
REQ-014 fail  output  1  one-cycle pulse on timeout or false start.
REQ-015 elapsed  output  CNT_W  reaction time of the current or last round in cycles.
REQ-016 highscore  output  CNT_W  smallest successful elapsed since reset.

Function
REQ-017 FSM states IDLE, ARM, SHOW, DONE; key_rise = key high this cycle and low the previous cycle.
REQ-018 IDLE: on key_rise with selection high -> ARM, load arm counter with ARM_CYCLES-1, clear elapsed to 0.
REQ-019 ARM: decrement arm counter each cycle; at 0 -> SHOW, latch target into light.
REQ-020 ARM false start: key_rise in ARM -> DONE with fail pulse; takes priority over arm expiry in the same cycle.
REQ-021 Target: free-running 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, advances every cycle; target = low N_SW bits, replaced by 1 when zero.
REQ-022 SHOW: elapsed increments by 1 per cycle starting from 0 on the first SHOW cycle.
REQ-023 SHOW match: sw == light in the same cycle -> DONE, signal pulses next cycle, elapsed freezes at its value in the match cycle.
REQ-024 SHOW timeout: elapsed == TIMEOUT-1 without match -> DONE, fail pulses, elapsed freezes at TIMEOUT-1; match wins over timeout in the same cycle.
REQ-025 Highscore: updated in the match cycle to elapsed when elapsed < highscore (strict); equal or greater values leave it unchanged; fail never updates it.
REQ-026 DONE: light = 0; stays until key is low, then -> IDLE; elapsed holds until the next ARM entry.
REQ-027 selection low in any state: next cycle -> IDLE, light = 0, no signal/fail pulse, elapsed and highscore held.
REQ-028 signal and fail are never high together; each is high for exactly one cycle per round.
REQ-029 Counters never wrap; elapsed cannot exceed TIMEOUT-1.

Reset
REQ-030 rst high: state IDLE, light 0, armed 0, signal 0, fail 0, elapsed 0, highscore all ones, LFSR 16'hACE1, key history 0.
REQ-031 Reset takes effect immediately mid-round, and the block restarts from IDLE on the first cin edge after rst falls.

Verification
REQ-032 Reset then selection=1, key pulse, ARM_CYCLES=4 -> armed high for 4 cycles, light nonzero on next cycle.
REQ-033 In SHOW drive sw=light after 10 cycles -> signal one pulse, elapsed=10, highscore=10.
REQ-034 Second round matched at 12 then third at 7 -> highscore stays 10, then becomes 7.
REQ-035 Key pulse during ARM -> fail pulse, light stays 0, highscore unchanged.
REQ-036 TIMEOUT=20, no match -> fail pulse, elapsed=19, signal never high.
REQ-037 selection dropped in SHOW, and rst asserted mid-ARM -> IDLE with light 0; after reset highscore=all ones, elapsed=0.

Source files
------------

// File: rtl/reaction_match_mode.sv
// Reaction-time match game: arm delay, random target on the LEDs, time the
// player until the switches match, and keep the best (smallest) time.
module reaction_match_mode #(
  parameter int N_SW       = 8,
  parameter int CNT_W      = 24,
  parameter int ARM_CYCLES = 1500,
  parameter int TIMEOUT    = 5000000
) (
  input  logic             cin,
  input  logic             rst,
  input  logic             selection,
  input  logic             key,
  input  logic [N_SW-1:0]  sw,
  output logic [N_SW-1:0]  light,
  output logic             armed,
  output logic             signal,
  output logic             fail,
  output logic [CNT_W-1:0] elapsed,
  output logic [CNT_W-1:0] highscore
);

  localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LOAD    = ARM_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] ELAPSED_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [15:0]      LFSR_SEED   = 16'hACE1;
  localparam logic [15:0]      LFSR_TAPS   = 16'hB400;

  typedef enum logic [1:0] {IDLE, ARM, SHOW, DONE} state_t;

  state_t           state;
  logic [ARM_W-1:0] arm_cnt;
  logic [15:0]      lfsr;
  logic             key_q;
  logic             key_rise;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // An all-zero target would be unmatchable-looking dark LEDs, so force bit 0.
  function automatic logic [N_SW-1:0] target_of(input logic [15:0] s);
    logic [N_SW-1:0] t;
    t = s[N_SW-1:0];
    return (t == '0) ? N_SW'(1) : t;
  endfunction

  assign key_rise = key & ~key_q;

  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      arm_cnt   <= '0;
      lfsr      <= LFSR_SEED;
      key_q     <= 1'b0;
      light     <= '0;
      armed     <= 1'b0;
      signal    <= 1'b0;
      fail      <= 1'b0;
      elapsed   <= '0;
      highscore <= '1;
    end else begin
      key_q  <= key;
      lfsr   <= lfsr_next(lfsr);
      signal <= 1'b0;
      fail   <= 1'b0;
      if (!selection) begin
        state <= IDLE;
        light <= '0;
        armed <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (key_rise) begin
              state   <= ARM;
              armed   <= 1'b1;
              arm_cnt <= ARM_LOAD;
              elapsed <= '0;
            end
          end
          ARM: begin
            // A fresh press while armed is a false start, even on the expiry cycle.
            if (key_rise) begin
              state <= DONE;
              armed <= 1'b0;
              fail  <= 1'b1;
            end else if (arm_cnt == '0) begin
              state <= SHOW;
              armed <= 1'b0;
              light <= target_of(lfsr);
            end else begin
              arm_cnt <= arm_cnt - 1'b1;
            end
          end
          SHOW: begin
            if (sw == light) begin
              state  <= DONE;
              light  <= '0;
              signal <= 1'b1;
              if (elapsed < highscore) highscore <= elapsed;
            end else if (elapsed == ELAPSED_MAX) begin
              state <= DONE;
              light <= '0;
              fail  <= 1'b1;
            end else begin
              elapsed <= elapsed + 1'b1;
            end
          end
          DONE: begin
            if (!key) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_match_mode.sv
// Bench for reaction_match_mode: randomized rounds against a reference model
// of the target generator and the best-time rule.
module tb_reaction_match_mode;
  localparam int N_SW = 8, CNT_W = 16, ARM_CYCLES = 4, TIMEOUT = 20;

  logic cin = 1'b0;
  logic rst = 1'b1, selection = 1'b0, key = 1'b0;
  logic [N_SW-1:0] sw = '0, light;
  logic armed, signal, fail;
  logic [CNT_W-1:0] elapsed, highscore;

  int tests_run = 0, tests_failed = 0;
  logic [CNT_W-1:0] exp_high;
  logic [15:0] m_lfsr, m_prev;

  always #5 cin = ~cin;

  reaction_match_mode #(.N_SW(N_SW), .CNT_W(CNT_W), .ARM_CYCLES(ARM_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .cin(cin), .rst(rst), .selection(selection), .key(key), .sw(sw),
    .light(light), .armed(armed), .signal(signal), .fail(fail),
    .elapsed(elapsed), .highscore(highscore)
  );

  // Feedback mask built from the polynomial exponents 14, 13, 11 and 16.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] mask;
    mask = (16'h1 << (16 - 1)) | (16'h1 << (14 - 1)) | (16'h1 << (13 - 1)) | (16'h1 << (11 - 1));
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  function automatic logic [N_SW-1:0] target(input logic [15:0] s);
    logic [N_SW-1:0] t;
    t = s[N_SW-1:0];
    if (t == '0) t = 1;
    return t;
  endfunction

  // m_prev is the generator value the DUT saw on the most recent edge.
  always @(posedge cin or posedge rst) begin
    if (rst) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge cin);
    #1;
  endtask

  task automatic arm_round;
    int n;
    key = 1'b1;
    tick;
    key = 1'b0;
    n = 0;
    while (armed === 1'b1 && n < 100) begin
      n++;
      tick;
    end
    tests_run++;
    if (n !== ARM_CYCLES) begin
      tests_failed++;
      $display("FAIL arm_length: got %0d cycles expected %0d", n, ARM_CYCLES);
    end
    tests_run++;
    if (light !== target(m_prev)) begin
      tests_failed++;
      $display("FAIL target: got %h expected %h", light, target(m_prev));
    end
  endtask

  task automatic match_after(input int d);
    sw = ~light;
    repeat (d) tick;
    sw = light;
    tick;
    if (d < exp_high) exp_high = CNT_W'(d);
    tests_run++;
    if (signal !== 1'b1 || fail !== 1'b0) begin
      tests_failed++;
      $display("FAIL match_pulse: got signal=%b fail=%b expected signal=1 fail=0", signal, fail);
    end
    tests_run++;
    if (elapsed !== CNT_W'(d)) begin
      tests_failed++;
      $display("FAIL match_elapsed: got %0d expected %0d", elapsed, d);
    end
    tests_run++;
    if (highscore !== exp_high) begin
      tests_failed++;
      $display("FAIL highscore: got %0d expected %0d", highscore, exp_high);
    end
    sw = '0;
    tick;
    tests_run++;
    if (signal !== 1'b0 || light !== '0) begin
      tests_failed++;
      $display("FAIL after_match: got signal=%b light=%h expected 0 and 00", signal, light);
    end
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    tests_run++;
    if (light !== '0 || armed !== 1'b0 || signal !== 1'b0 || fail !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got light=%h armed=%b signal=%b fail=%b expected all 0", light, armed, signal, fail);
    end
    tests_run++;
    if (elapsed !== '0 || highscore !== '1) begin
      tests_failed++;
      $display("FAIL reset_counts: got elapsed=%0d high=%h expected 0 and ffff", elapsed, highscore);
    end
    exp_high = '1;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_first_round;
    selection = 1'b1;
    tick;
    arm_round;
    match_after(10);
  endtask

  task automatic test_back_to_back;
    arm_round;
    match_after(12);
    arm_round;
    match_after(7);
  endtask

  task automatic test_random_rounds;
    for (int r = 0; r < 8; r++) begin
      arm_round;
      match_after(int'($urandom_range(0, TIMEOUT - 1)));
    end
  endtask

  task automatic test_false_start;
    key = 1'b1; tick;
    key = 1'b0; tick;
    key = 1'b1; tick;
    tests_run++;
    if (fail !== 1'b1 || signal !== 1'b0 || light !== '0 || armed !== 1'b0) begin
      tests_failed++;
      $display("FAIL false_start: got fail=%b signal=%b light=%h armed=%b expected 1 0 00 0", fail, signal, light, armed);
    end
    tick;
    tests_run++;
    if (fail !== 1'b0 || light !== '0) begin
      tests_failed++;
      $display("FAIL false_start_hold: got fail=%b light=%h expected 0 00", fail, light);
    end
    key = 1'b0;
    tick;
    tick;
    tests_run++;
    if (highscore !== exp_high) begin
      tests_failed++;
      $display("FAIL false_start_high: got %0d expected %0d", highscore, exp_high);
    end
    // Press lands exactly on the arm-expiry cycle.
    key = 1'b1; tick;
    key = 1'b0; repeat (ARM_CYCLES - 1) tick;
    key = 1'b1; tick;
    tests_run++;
    if (fail !== 1'b1 || light !== '0) begin
      tests_failed++;
      $display("FAIL false_start_expiry: got fail=%b light=%h expected 1 00", fail, light);
    end
    key = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_timeout;
    int sigs, fails, at;
    arm_round;
    sw = ~light;
    sigs = 0; fails = 0; at = 0;
    for (int k = 1; k <= TIMEOUT + 3; k++) begin
      tick;
      if (signal === 1'b1) sigs++;
      if (fail === 1'b1) begin
        fails++;
        at = k;
      end
    end
    tests_run++;
    if (fails !== 1 || at !== TIMEOUT || sigs !== 0) begin
      tests_failed++;
      $display("FAIL timeout_pulse: got fails=%0d at=%0d signals=%0d expected 1 %0d 0", fails, at, sigs, TIMEOUT);
    end
    tests_run++;
    if (elapsed !== CNT_W'(TIMEOUT - 1) || highscore !== exp_high) begin
      tests_failed++;
      $display("FAIL timeout_counts: got elapsed=%0d high=%0d expected %0d %0d", elapsed, highscore, TIMEOUT - 1, exp_high);
    end
    sw = '0;
    tick;
  endtask

  task automatic test_selection_drop;
    arm_round;
    sw = ~light;
    repeat (5) tick;
    selection = 1'b0;
    tick;
    tests_run++;
    if (light !== '0 || armed !== 1'b0 || signal !== 1'b0 || fail !== 1'b0) begin
      tests_failed++;
      $display("FAIL sel_drop: got light=%h armed=%b signal=%b fail=%b expected all 0", light, armed, signal, fail);
    end
    tests_run++;
    if (elapsed !== CNT_W'(5) || highscore !== exp_high) begin
      tests_failed++;
      $display("FAIL sel_drop_hold: got elapsed=%0d high=%0d expected 5 %0d", elapsed, highscore, exp_high);
    end
    sw = '0;
    tick;
    selection = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid_arm;
    key = 1'b1; tick;
    key = 1'b0; tick;
    tests_run++;
    if (armed !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_arm: got armed=%b expected 1", armed);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (armed !== 1'b0 || light !== '0 || elapsed !== '0 || highscore !== '1) begin
      tests_failed++;
      $display("FAIL async_reset: got armed=%b light=%h elapsed=%0d high=%h expected 0 00 0 ffff", armed, light, elapsed, highscore);
    end
    exp_high = '1;
    tick;
    rst = 1'b0;
    tick;
    arm_round;
    match_after(9);
  endtask

  initial begin
    test_reset;
    test_first_round;
    test_back_to_back;
    test_false_start;
    test_timeout;
    test_selection_drop;
    test_random_rounds;
    test_reset_mid_arm;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
